// File: rtl/int_irq_gen_if.sv
// CPU register bus between a CPU-side master and the interrupt generator.
// Master drives read/write strobes, register select and write data; slave returns read data.
// Ports: cpuren_i, cpuwen_i, cpuaddr_i, cpudi_i (master -> slave), cpudo_o (slave -> master).
interface int_irq_gen_if #(
  parameter int DW = 8
);
  logic          cpuren_i;
  logic          cpuwen_i;
  logic [1:0]    cpuaddr_i;
  logic [DW-1:0] cpudi_i;
  logic [DW-1:0] cpudo_o;

  modport master (
    output cpuren_i,
    output cpuwen_i,
    output cpuaddr_i,
    output cpudi_i,
    input  cpudo_o
  );

  modport slave (
    input  cpuren_i,
    input  cpuwen_i,
    input  cpuaddr_i,
    input  cpudi_i,
    output cpudo_o
  );
endinterface

// File: rtl/int_irq_gen.sv
// Interrupt request generator: masks latched status, optionally coalesces, drives irq_o (level or pulse).
// Latency: irq_o rises 1 cycle after pending status appears with TMO=0, TMO+1 cycles otherwise.
// No backpressure: register reads are combinational, writes land on the next clock edge.
// Ports: clk, rst_n (async active-low), cpu (register bus, slave side), sts_i (status), irq_o (registered).
module int_irq_gen #(
  parameter int DW   = 8,
  parameter int CNTW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  int_irq_gen_if.slave  cpu,
  input  logic [DW-1:0] sts_i,
  output logic          irq_o
);

  localparam logic [1:0] ADDR_MASK = 2'd0;
  localparam logic [1:0] ADDR_CTRL = 2'd1;
  localparam logic [1:0] ADDR_PEND = 2'd2;
  localparam logic [1:0] ADDR_TMO  = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    ASSERT   = 2'd2,
    WAIT_CLR = 2'd3
  } state_t;

  logic [DW-1:0]   mask;
  logic            en;
  logic            mode;
  logic [CNTW-1:0] tmo;

  logic [DW-1:0]   pend;
  logic [DW-1:0]   pend_q;
  logic            act;
  logic            newbit;

  state_t          state, state_nxt;
  logic [CNTW-1:0] cnt, cnt_nxt;

  logic [DW-1:0]   ctrl_rd;
  logic [DW-1:0]   tmo_rd;

  // Register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= '0;
      en   <= 1'b0;
      mode <= 1'b0;
      tmo  <= '0;
    end else if (cpu.cpuwen_i) begin
      case (cpu.cpuaddr_i)
        ADDR_MASK: mask <= cpu.cpudi_i;
        ADDR_CTRL: begin
          en   <= cpu.cpudi_i[0];
          mode <= cpu.cpudi_i[1];
        end
        ADDR_TMO:  tmo <= cpu.cpudi_i[CNTW-1:0];
        default:   ;  // PEND is read-only
      endcase
    end
  end

  assign pend   = sts_i & mask;
  assign act    = en & (|pend);
  assign newbit = |(pend & ~pend_q);

  // Zero-extended read views; built bitwise so DW == CNTW needs no special case
  always_comb begin
    ctrl_rd    = '0;
    ctrl_rd[0] = en;
    ctrl_rd[1] = mode;
    tmo_rd     = '0;
    tmo_rd[CNTW-1:0] = tmo;
  end

  always_comb begin
    cpu.cpudo_o = '0;
    if (cpu.cpuren_i) begin
      case (cpu.cpuaddr_i)
        ADDR_MASK: cpu.cpudo_o = mask;
        ADDR_CTRL: cpu.cpudo_o = ctrl_rd;
        ADDR_PEND: cpu.cpudo_o = pend;
        ADDR_TMO:  cpu.cpudo_o = tmo_rd;
        default:   cpu.cpudo_o = '0;
      endcase
    end
  end

  // State, counter, previous-pend and irq registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      pend_q <= '0;
      irq_o  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      pend_q <= pend;
      irq_o  <= (state_nxt == ASSERT);
    end
  end

  // Losing act (EN cleared, status gone, mask cleared) wins over every state.
  // The counter is only loaded from IDLE, so a TMO write during HOLD leaves the running count alone.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!act) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (tmo == '0) begin
            state_nxt = ASSERT;
          end else begin
            state_nxt = HOLD;
            cnt_nxt   = tmo;
          end
        end
        HOLD: begin
          // Stops at 1 on the way out, so it can never wrap
          if (cnt == CNTW'(1)) state_nxt = ASSERT;
          else                 cnt_nxt   = cnt - CNTW'(1);
        end
        ASSERT: begin
          if (mode) state_nxt = WAIT_CLR;
        end
        WAIT_CLR: begin
          if (newbit) state_nxt = ASSERT;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule
